// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets within the I/O
// window, status register bit positions and the default window base.
package mmio_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [7:0] STATUS   = 8'h00;
  localparam logic [7:0] RX_DATA  = 8'h04;
  localparam logic [7:0] TX_DATA  = 8'h08;
  localparam logic [7:0] CYCLE    = 8'h10;
  localparam logic [7:0] INSTRET  = 8'h14;
  localparam logic [7:0] CNT_RST  = 8'h18;
  localparam logic [7:0] BR_CNT   = 8'h1C;
  localparam logic [7:0] BR_TAKEN = 8'h20;

  localparam int STAT_TX_NOT_FULL = 0;
  localparam int STAT_RX_HELD     = 1;
  localparam int STAT_TX_OVF      = 2;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART transmitter. DEPTH must be a
// power of two (>= 2); pointers carry one extra wrap bit to tell full from empty.
module mmio_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_responder.sv
// Load/store responder for the core's 0x8000_00xx I/O window: UART TX FIFO,
// RX holding register, cycle/instret counters. Define MMIO_BRANCH_STATS_EN
// to add the branch-retired and branch-taken counters.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int          TX_DEPTH = 8,
  parameter logic [31:0] BASE     = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wmask,
  input  logic        req_re,
  input  logic        inst_retire,
`ifdef MMIO_BRANCH_STATS_EN
  input  logic        br_retire,
  input  logic        br_taken,
`endif
  output logic [31:0] rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic        in_win;
  logic [7:0]  offset;
  logic        wr_en;
  logic        rd_en;
  logic        tx_push;
  logic        tx_pop;
  logic        tx_full;
  logic        tx_empty;
  logic        cnt_clr;
  logic        rx_pop;
  logic        rx_held;
  logic [7:0]  rx_byte;
  logic        tx_ovf;
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
  logic [31:0] rd_value;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[1:0], req_wdata[31:8]};

  assign in_win  = (req_addr[31:8] == BASE[31:8]);
  assign offset  = {req_addr[7:2], 2'b00};
  assign wr_en   = in_win && (|req_wmask);
  assign rd_en   = in_win && req_re;
  assign tx_push = wr_en && (offset == TX_DATA);
  assign cnt_clr = wr_en && (offset == CNT_RST);
  assign rx_pop  = rd_en && (offset == RX_DATA) && rx_held;
  assign tx_pop  = tx_valid && tx_ready;

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_held;

  mmio_tx_fifo #(
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .wdata (req_wdata[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .head  (tx_data)
  );

`ifdef MMIO_BRANCH_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] br_taken_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else if (cnt_clr) begin
      br_cnt       <= '0;
      br_taken_cnt <= '0;
    end else begin
      br_cnt       <= br_cnt + {31'd0, br_retire};
      br_taken_cnt <= br_taken_cnt + {31'd0, br_retire && br_taken};
    end
  end
`endif

  // Read mux sees pre-edge state, so a same-cycle write is not visible.
  always_comb begin
    rd_value = '0;
    case (offset)
      STATUS: begin
        rd_value[STAT_TX_NOT_FULL] = !tx_full;
        rd_value[STAT_RX_HELD]     = rx_held;
        rd_value[STAT_TX_OVF]      = tx_ovf;
      end
      RX_DATA: if (rx_held) rd_value = {24'd0, rx_byte};
      CYCLE:   rd_value = cycle_cnt;
      INSTRET: rd_value = instret_cnt;
`ifdef MMIO_BRANCH_STATS_EN
      BR_CNT:   rd_value = br_cnt;
      BR_TAKEN: rd_value = br_taken_cnt;
`endif
      default: rd_value = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else        rdata <= rd_en ? rd_value : 32'd0;
  end

  // Pop and load are mutually exclusive: a byte is only accepted while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_held <= 1'b0;
      rx_byte <= '0;
    end else if (rx_pop) begin
      rx_held <= 1'b0;
    end else if (rx_valid && !rx_held) begin
      rx_held <= 1'b1;
      rx_byte <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      tx_ovf      <= 1'b0;
    end else if (cnt_clr) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
      tx_ovf      <= 1'b0;
    end else begin
      cycle_cnt   <= cycle_cnt + 32'd1;
      instret_cnt <= instret_cnt + {31'd0, inst_retire};
      if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: queue-based reference model checked
// every cycle, plus directed vectors with hand-computed expectations.
module tb_mmio_responder;

  localparam int          TX_DEPTH = 8;
  localparam logic [31:0] BASE     = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wmask;
  logic        req_re;
  logic        inst_retire;
  logic        br_retire;
  logic        br_taken;
  logic [31:0] rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks = 0;
  int errors = 0;

  mmio_responder #(
    .TX_DEPTH (TX_DEPTH),
    .BASE     (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .req_re      (req_re),
    .inst_retire (inst_retire),
`ifdef MMIO_BRANCH_STATS_EN
    .br_retire   (br_retire),
    .br_taken    (br_taken),
`endif
    .rdata       (rdata),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_txq[$];
  logic [31:0] m_cyc, m_inst, m_brc, m_brt;
  logic        m_ovf, m_held;
  logic [7:0]  m_rxb;
  logic [31:0] m_rdata;
  logic        m_inwin, m_wr, m_popped, m_was_held;
  logic [7:0]  m_off;

  function automatic logic [31:0] modelRead(input logic [7:0] off);
    logic [31:0] v;
    v = '0;
    case (off)
      8'h00: begin
        v[0] = (m_txq.size() < TX_DEPTH);
        v[1] = m_held;
        v[2] = m_ovf;
      end
      8'h04: v = m_held ? {24'd0, m_rxb} : 32'd0;
      8'h10: v = m_cyc;
      8'h14: v = m_inst;
`ifdef MMIO_BRANCH_STATS_EN
      8'h1C: v = m_brc;
      8'h20: v = m_brt;
`endif
      default: v = '0;
    endcase
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_txq.delete();
      m_cyc = 0; m_inst = 0; m_brc = 0; m_brt = 0;
      m_ovf = 0; m_held = 0; m_rxb = 0; m_rdata = 0;
    end else begin
      m_inwin = (req_addr[31:8] == BASE[31:8]);
      m_off   = {req_addr[7:2], 2'b00};
      m_wr    = m_inwin && (req_wmask != 4'd0);
      m_rdata = (req_re && m_inwin) ? modelRead(m_off) : 32'd0;
      m_popped = req_re && m_inwin && (m_off == 8'h04) && m_held;
      if (m_txq.size() > 0 && tx_ready) void'(m_txq.pop_front());
      if (m_wr && m_off == 8'h08) begin
        if (m_txq.size() < TX_DEPTH) m_txq.push_back(req_wdata[7:0]);
        else m_ovf = 1;
      end
      m_was_held = m_held;
      if (m_popped) m_held = 0;
      else if (!m_was_held && rx_valid) begin
        m_held = 1;
        m_rxb  = rx_data;
      end
      if (m_wr && m_off == 8'h18) begin
        m_cyc = 0; m_inst = 0; m_ovf = 0; m_brc = 0; m_brt = 0;
      end else begin
        m_cyc  = m_cyc + 1;
        m_inst = m_inst + 32'(inst_retire);
        m_brc  = m_brc + 32'(br_retire);
        m_brt  = m_brt + 32'(br_retire && br_taken);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      checkOutput("rdata", rdata, m_rdata);
      checkOutput("tx_valid", 32'(tx_valid), 32'(m_txq.size() > 0));
      if (m_txq.size() > 0) checkOutput("tx_data", 32'(tx_data), 32'(m_txq[0]));
      checkOutput("rx_ready", 32'(rx_ready), 32'(!m_held));
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wmask, input logic re);
    @(negedge clk);
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_re    = re;
    @(negedge clk);
    req_re    = 1'b0;
    req_wmask = 4'd0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  logic [31:0] c1, c2;

  initial begin
    rst_n = 0; req_addr = 0; req_wdata = 0; req_wmask = 0; req_re = 0;
    inst_retire = 0; br_retire = 0; br_taken = 0;
    tx_ready = 0; rx_data = 0; rx_valid = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'h1);
    rst_n = 1;

    $display("[TB] status and cycle counter after reset");
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_after_reset", rdata, 32'h1);
    applyStimulus(BASE | 32'h10, 0, 4'd0, 1);
    c1 = rdata;
    repeat (3) @(negedge clk);
    applyStimulus(BASE | 32'h13, 0, 4'd0, 1);
    c2 = rdata;
    checkOutput("cycle_delta", c2 - c1, 32'd5);

    $display("[TB] TX ordering");
    applyStimulus(BASE | 32'h08, 32'h41, 4'b0001, 0);
    applyStimulus(BASE | 32'h08, 32'hFF42, 4'b1111, 0);
    applyStimulus(BASE | 32'h08, 32'h43, 4'b0010, 0);
    checkOutput("tx_valid_after_push", 32'(tx_valid), 32'h1);
    checkOutput("tx_head_first", 32'(tx_data), 32'h41);
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("tx_order", 32'(tx_data), 32'h41 + i);
      @(negedge clk);
    end
    tx_ready = 0;
    checkOutput("tx_drained", 32'(tx_valid), 32'h0);

    $display("[TB] TX full and overflow");
    for (int i = 0; i < 9; i++) applyStimulus(BASE | 32'h08, 32'h60 + i, 4'b0001, 0);
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_full_ovf", rdata, 32'h4);
    applyStimulus(BASE | 32'h18, 0, 4'hF, 0);
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_full_cleared", rdata, 32'h0);
    @(negedge clk);
    tx_ready = 1; req_addr = BASE | 32'h08; req_wdata = 32'h99; req_wmask = 4'b0001;
    @(negedge clk);
    tx_ready = 0; req_wmask = 0;
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_full_pushpop", rdata, 32'h0);
    tx_ready = 1;
    repeat (10) @(negedge clk);
    tx_ready = 0;
    checkOutput("tx_drained_full", 32'(tx_valid), 32'h0);

    $display("[TB] RX holding register");
    rx_data = 8'h5A; rx_valid = 1;
    @(negedge clk);
    rx_valid = 0;
    checkOutput("rx_ready_held", 32'(rx_ready), 32'h0);
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_rx_held", rdata, 32'h3);
    applyStimulus(BASE | 32'h04, 0, 4'd0, 1);
    checkOutput("rx_read", rdata, 32'h5A);
    applyStimulus(BASE | 32'h04, 0, 4'd0, 1);
    checkOutput("rx_read_empty", rdata, 32'h0);
    rx_data = 8'h5A; rx_valid = 1;
    @(negedge clk);
    rx_data = 8'h77; req_addr = BASE | 32'h04; req_re = 1;
    @(negedge clk);
    req_re = 0;
    checkOutput("rx_pop_collide", rdata, 32'h5A);
    @(negedge clk);
    rx_valid = 0;
    applyStimulus(BASE | 32'h04, 0, 4'd0, 1);
    checkOutput("rx_late_accept", rdata, 32'h77);

    $display("[TB] instret and counter clear");
    inst_retire = 1;
    repeat (10) @(negedge clk);
    inst_retire = 0;
    applyStimulus(BASE | 32'h14, 0, 4'd0, 1);
    checkOutput("instret_10", rdata, 32'd10);
    @(negedge clk);
    inst_retire = 1; req_addr = BASE | 32'h18; req_wdata = 0; req_wmask = 4'b0100;
    @(negedge clk);
    inst_retire = 0; req_wmask = 0;
    applyStimulus(BASE | 32'h10, 0, 4'd0, 1);
    checkOutput("cycle_after_clear", rdata, 32'd1);
    applyStimulus(BASE | 32'h14, 0, 4'd0, 1);
    checkOutput("instret_after_clear", rdata, 32'd0);
    applyStimulus(32'h8000_0110, 0, 4'd0, 1);
    checkOutput("out_of_window", rdata, 32'd0);

    $display("[TB] branch statistics");
`ifdef MMIO_BRANCH_STATS_EN
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      br_retire = (i != 2);
      br_taken  = (i != 1);
    end
    @(negedge clk);
    br_retire = 0; br_taken = 0;
    applyStimulus(BASE | 32'h1C, 0, 4'd0, 1);
    checkOutput("br_cnt", rdata, 32'd4);
    applyStimulus(BASE | 32'h20, 0, 4'd0, 1);
    checkOutput("br_taken_cnt", rdata, 32'd3);
    applyStimulus(BASE | 32'h18, 0, 4'hF, 0);
    applyStimulus(BASE | 32'h1C, 0, 4'd0, 1);
    checkOutput("br_cnt_cleared", rdata, 32'd0);
`else
    applyStimulus(BASE | 32'h1C, 0, 4'd0, 1);
    checkOutput("br_cnt_absent", rdata, 32'd0);
    applyStimulus(BASE | 32'h20, 0, 4'd0, 1);
    checkOutput("br_taken_absent", rdata, 32'd0);
`endif

    $display("[TB] reset mid-transfer");
    applyStimulus(BASE | 32'h08, 32'h11, 4'b0001, 0);
    applyStimulus(BASE | 32'h08, 32'h22, 4'b0001, 0);
    checkOutput("tx_valid_before_reset", 32'(tx_valid), 32'h1);
    #3;
    rst_n = 0;
    #1;
    checkOutput("tx_valid_async_drop", 32'(tx_valid), 32'h0);
    checkOutput("rdata_async_reset", rdata, 32'h0);
    @(negedge clk);
    rst_n = 1;
    applyStimulus(BASE | 32'h00, 0, 4'd0, 1);
    checkOutput("status_after_midreset", rdata, 32'h1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder for the 3-stage RISC-V core; the data side of the core's load/store interface for the 0x8000_00xx I/O window.
- The execute stage issues requests. This block returns registered read data, which is consumed in mem/wb (1-cycle latency).
- Contains the UART TX FIFO, the UART RX holding register, and the cycle and retired-instruction counters.

Parameters:
- TX_DEPTH, 8, TX FIFO entries; must be a power of two, at least 2.
- BASE, 32'h8000_0000, base address of the I/O window; the decoder compares addr[31:8].

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_addr  in  32  byte address from execute stage.
- req_wdata  in  32  store data, already lane-aligned.
- req_wmask  in  4  byte-write mask; all-zero means no write.
- req_re  in  1  load request this cycle.
- inst_retire  in  1  one pulse per instruction leaving mem/wb.
- rdata  out  32  load response, valid the cycle after req_re.
- tx_data  out  8  byte to UART transmitter.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  UART transmitter accepts tx_data.
- rx_data  in  8  byte from UART receiver.
- rx_valid  in  1  receiver offers a byte.
- rx_ready  out  1  holding register empty.

Behaviour:
- Reset (async, rst_n=0):
  - rdata=0, tx_valid=0, rx_ready=1.
  - FIFO pointers=0, counters=0, overflow=0, holding register empty.
- Decode: a request is in-window when req_addr[31:8]==BASE[31:8]. Offsets are word-aligned; req_addr[1:0] is ignored.
- Register map (offset, access, meaning):
  - 0x00 R, status: bit0 = tx FIFO not full, bit1 = rx byte held, bit2 = sticky tx overflow; other bits 0.
  - 0x04 R, rx byte zero-extended. Reading pops the holding register. If empty, returns 0 and has no effect.
  - 0x08 W, tx push of req_wdata[7:0]; any nonzero req_wmask triggers the push. If FIFO full, the byte is dropped and overflow is set.
  - 0x10 R, cycle counter.
  - 0x14 R, retired-instruction counter.
  - 0x18 W, any write clears both counters and overflow.
  - All other offsets: reads return 0, writes are ignored.
- Read path:
  - rdata is registered: rdata <= decoded value when req_re and in-window, else 0.
  - Pop side effects commit on the same edge as the rdata update.
- req_re and a nonzero req_wmask in the same cycle: the write is applied and the read returns the pre-write value.
- Cycle counter:
  - +1 every cycle, wraps at 2^32.
  - The instret counter adds inst_retire, wraps at 2^32.
  - A clear write wins over the same-cycle increment: counter = 0 next cycle.
- TX FIFO:
  - tx_data = head entry, combinational from storage.
  - Pop on tx_valid && tx_ready.
  - Push and pop in the same cycle when full: the pop frees a slot, so the push is accepted and overflow is not set.
  - Push while empty: tx_valid rises the next cycle; no bypass.
  - Pointers are log2(TX_DEPTH)+1 bits wide; the MSB distinguishes full from empty.
- RX holding register:
  - Loads on rx_valid && rx_ready; rx_ready = !held.
  - A CPU pop and an rx_valid arrival in the same cycle: the pop returns the old byte, the new byte is not accepted that cycle (rx_ready was 0), and it is accepted the following cycle.
- Reset mid-transfer: FIFO contents are discarded and tx_valid drops asynchronously. The UART transmitter must tolerate tx_valid being withdrawn.

Optional Feature:
- Macro MMIO_BRANCH_STATS_EN.
- Enabled:
  - Adds inputs br_retire (1) and br_taken (1).
  - Adds two 32-bit counters: branches retired at 0x1C, taken branches at 0x20.
  - Both are cleared by a write to 0x18 under the same clear-wins rule.
- Disabled: ports absent; 0x1C and 0x20 read 0.

Decomposition:
- Package mmio_pkg:
  - Offset constants (STATUS, RX_DATA, TX_DATA, CYCLE, INSTRET, CNT_RST, BR_CNT, BR_TAKEN).
  - Status bit indices.
  - BASE default.
- Sub-module mmio_tx_fifo: parameterised synchronous FIFO with push/pop/full/empty/head; the only natural split.
- Counters, RX holding register, and decode stay in mmio_responder.

Test Plan:
- Reset release: read 0x00 -> rdata=32'h1 one cycle after req_re. Read 0x10 twice, 5 cycles apart -> difference of 5.
- Write 0x41,0x42,0x43 to 0x08 with tx_ready=0 -> tx_valid=1, tx_data=0x41. Then tx_ready=1 for 3 cycles -> bytes 41,42,43 in order, then tx_valid=0.
- TX_DEPTH=8, tx_ready=0: 9 pushes -> status=32'h4 (full, overflow). Push while full with tx_ready=1 in the same cycle -> accepted, overflow unchanged.
- rx_valid with 0x5A -> rx_ready=0 next cycle, status bit1=1. Read 0x04 -> rdata=0x5A. Read again -> rdata=0.
- 10 inst_retire pulses, then write 0x18 in the same cycle as a pulse -> 0x14 reads 0 and 0x10 reads 1 on the next read.
- MMIO_BRANCH_STATS_EN: 4 br_retire, 3 with br_taken -> 0x1C=4, 0x20=3. Build without the macro -> both read 0.
